// File: rtl/master_cpu_sequencer.sv
// Instruction sequencer for a small load/store CPU: fetches from a
// one-cycle-latency instruction RAM, steps EXEC/MEM/WB and halts after
// PROG_LEN instructions, on OP_HALT, or on a data-memory timeout.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | after reset, waiting for Start
// S_FETCH | instruction RAM enabled at Pc
// S_LATCH | RAM data captured into Instr_reg
// S_EXEC  | decode, condition check, memory timer armed
// S_MEM   | data RAM access, waiting for Mem_ready or timeout
// S_WB    | writeback strobe, Retired/Pc advance
// S_HALT  | stopped; Start restarts from address 0
module master_cpu_sequencer #(
  parameter int         IADDR_W     = 8,
  parameter int         PROG_LEN    = 16,
  parameter logic [3:0] OP_LDR      = 4'b1000,
  parameter logic [3:0] OP_STR      = 4'b1001,
  parameter logic [3:0] OP_HALT     = 4'b1111,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [31:0]        Instr_in,
  input  logic               Cond_pass,
  input  logic               Mem_ready,
  output logic               Enable_i,
  output logic [IADDR_W-1:0] Address_in_i,
  output logic [31:0]        Instr_reg,
  output logic               Mem_en,
  output logic               Mem_rw,
  output logic               Reg_we,
  output logic [IADDR_W-1:0] Pc,
  output logic               Busy,
  output logic               Halted,
  output logic               Mem_err,
  output logic [15:0]        Retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);
  // When PROG_LEN fills the whole address space the final Pc value is not
  // representable, so Pc holds at the last address instead of wrapping.
  localparam bit PC_HOLD = (PROG_LEN >= (1 << IADDR_W));

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr;
  logic               cond_q;
  logic [3:0]         opcode;
  logic [IADDR_W:0]   pc_inc;
  logic               prog_end;
  logic [IADDR_W-1:0] pc_wb;
  logic               is_mem_op;

  assign opcode    = Instr_reg[27:24];
  assign is_mem_op = (opcode == OP_LDR) || (opcode == OP_STR);
  assign pc_inc    = {1'b0, Pc} + {{IADDR_W{1'b0}}, 1'b1};
  assign prog_end  = (pc_inc == (IADDR_W + 1)'(PROG_LEN));
  assign pc_wb     = (PC_HOLD && prog_end) ? Pc : pc_inc[IADDR_W-1:0];
  assign Address_in_i = Pc;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: Pc, latched instruction, condition, memory timer, counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Pc        <= '0;
      Instr_reg <= '0;
      Retired   <= '0;
      Mem_err   <= 1'b0;
      cond_q    <= 1'b0;
      tmr       <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            Pc      <= '0;
            Retired <= '0;
            Mem_err <= 1'b0;
          end
        end
        S_LATCH: Instr_reg <= Instr_in;
        S_EXEC: begin
          cond_q <= Cond_pass;
          tmr    <= TMR_LOAD;
        end
        S_MEM: begin
          if (!Mem_ready) begin
            if (tmr == '0) Mem_err <= 1'b1;
            else           tmr     <= tmr - TMR_W'(1);
          end
        end
        S_WB: begin
          Pc <= pc_wb;
          if (Retired != 16'hFFFF) Retired <= Retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and per-state output strobes.
  always_comb begin
    state_nxt = state;
    Enable_i  = 1'b0;
    Mem_en    = 1'b0;
    Mem_rw    = 1'b1;
    Reg_we    = 1'b0;
    Busy      = 1'b0;
    Halted    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        Enable_i  = 1'b1;
        Busy      = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        Busy      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        Busy = 1'b1;
        if (opcode == OP_HALT) state_nxt = S_HALT;
        else if (!Cond_pass)   state_nxt = S_WB;
        else if (is_mem_op)    state_nxt = S_MEM;
        else                   state_nxt = S_WB;
      end
      S_MEM: begin
        Busy   = 1'b1;
        Mem_en = 1'b1;
        Mem_rw = (opcode == OP_LDR);
        // A response in the final allowed cycle still completes the access.
        if (Mem_ready)        state_nxt = S_WB;
        else if (tmr == '0)   state_nxt = S_HALT;
      end
      S_WB: begin
        Busy      = 1'b1;
        Reg_we    = cond_q && (opcode != OP_STR);
        state_nxt = prog_end ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        if (Start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_master_cpu_sequencer.sv
// Bench for master_cpu_sequencer: instruction RAM, condition table and a
// data-memory responder around the DUT, with an instruction-level model
// that predicts fetch addresses, strobe timing and final status.
module tb_master_cpu_sequencer;

  localparam int IADDR_W = 8;
  localparam int PROG_LEN = 16;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [3:0] OP_LDR = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_ALU = 4'b0001;

  logic Clk = 1'b0;
  logic Reset, Start;
  logic [31:0] Instr_in;
  logic Cond_pass, Mem_ready;
  logic Enable_i, Mem_en, Mem_rw, Reg_we, Busy, Halted, Mem_err;
  logic [IADDR_W-1:0] Address_in_i, Pc;
  logic [31:0] Instr_reg;
  logic [15:0] Retired;

  master_cpu_sequencer #(
    .IADDR_W(IADDR_W), .PROG_LEN(PROG_LEN), .OP_LDR(OP_LDR), .OP_STR(OP_STR),
    .OP_HALT(OP_HALT), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr_in(Instr_in),
    .Cond_pass(Cond_pass), .Mem_ready(Mem_ready), .Enable_i(Enable_i),
    .Address_in_i(Address_in_i), .Instr_reg(Instr_reg), .Mem_en(Mem_en),
    .Mem_rw(Mem_rw), .Reg_we(Reg_we), .Pc(Pc), .Busy(Busy), .Halted(Halted),
    .Mem_err(Mem_err), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  logic [31:0] imem [0:255];
  bit          cond_tbl [0:255];
  int          dly_tbl [0:255];   // 0 = never respond
  int          mem_cnt;

  always @(posedge Clk) if (Enable_i) Instr_in <= imem[Address_in_i];
  always @(posedge Clk) mem_cnt <= Mem_en ? mem_cnt + 1 : 0;
  assign Cond_pass = cond_tbl[Pc];
  assign Mem_ready = Mem_en && (dly_tbl[Pc] > 0) && (mem_cnt == dly_tbl[Pc] - 1);

  int checks = 0;
  int errors = 0;

  int exp_fetch[$], exp_we[$], exp_mem_s[$];
  bit exp_mem_rw[$];
  int exp_halt_s, exp_ret, exp_pc;
  bit exp_err;
  int act_fetch[$], act_we[$], act_mem_s[$];
  bit act_mem_rw[$];
  int first_halt;

  function automatic logic [31:0] mk_instr(input logic [3:0] op);
    logic [31:0] w;
    w = $urandom;
    w[27:24] = op;
    return w;
  endfunction

  task automatic load_alu_program();
    for (int i = 0; i < 256; i++) begin
      imem[i] = mk_instr(OP_ALU);
      cond_tbl[i] = 1'b1;
      dly_tbl[i] = 1;
    end
  endtask

  // Instruction-level model: walk the program and place each event at the
  // cycle it must appear, counted from the cycle after the Start edge.
  task automatic build_expect();
    int s0, pc, d;
    bit done, timeout;
    logic [3:0] op;
    exp_fetch.delete(); exp_we.delete(); exp_mem_s.delete(); exp_mem_rw.delete();
    exp_ret = 0; exp_err = 0; pc = 0; s0 = 0; done = 0; exp_halt_s = 0;
    while (!done) begin
      exp_fetch.push_back(pc);
      op = imem[pc][27:24];
      if (op == OP_HALT) begin
        exp_halt_s = s0 + 3;
        done = 1;
      end else begin
        d = 0; timeout = 0;
        if (cond_tbl[pc] && (op == OP_LDR || op == OP_STR)) begin
          if (dly_tbl[pc] >= 1 && dly_tbl[pc] <= MEM_TIMEOUT) d = dly_tbl[pc];
          else begin d = MEM_TIMEOUT; timeout = 1; end
          for (int k = 0; k < d; k++) begin
            exp_mem_s.push_back(s0 + 3 + k);
            exp_mem_rw.push_back(op == OP_LDR);
          end
        end
        if (timeout) begin
          exp_err = 1;
          exp_halt_s = s0 + 3 + d;
          done = 1;
        end else begin
          if (cond_tbl[pc] && op != OP_STR) exp_we.push_back(s0 + 3 + d);
          exp_ret++;
          pc++;
          s0 = s0 + 4 + d;
          if (pc == PROG_LEN) begin
            exp_halt_s = s0;
            done = 1;
          end
        end
      end
    end
    exp_pc = pc;
  endtask

  task automatic run_program(input string name, input bit noise);
    build_expect();
    act_fetch.delete(); act_we.delete(); act_mem_s.delete(); act_mem_rw.delete();
    first_halt = -1;
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    for (int s = 0; s <= exp_halt_s + 2; s++) begin
      @(negedge Clk);
      if (Enable_i) act_fetch.push_back(int'(Address_in_i));
      if (Reg_we) act_we.push_back(s);
      if (Mem_en) begin act_mem_s.push_back(s); act_mem_rw.push_back(Mem_rw); end
      if (Halted && first_halt < 0) first_halt = s;
      checks++;
      if (Busy !== (s < exp_halt_s)) begin
        errors++; $display("FAIL %s busy s=%0d got=%0b exp=%0b", name, s, Busy, s < exp_halt_s);
      end
      checks++;
      if ((int'(Enable_i) + int'(Mem_en) + int'(Reg_we)) > 1) begin
        errors++; $display("FAIL %s strobe_excl s=%0d got=%b exp=at_most_one", name, s, {Enable_i, Mem_en, Reg_we});
      end
      if (s == 0) begin
        checks++;
        if ({Retired, Mem_err, Halted} !== 18'd0) begin
          errors++; $display("FAIL %s start_clear ret=%0d err=%0b halt=%0b exp=0,0,0", name, Retired, Mem_err, Halted);
        end
      end
      Start = (noise && s < exp_halt_s) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    Start = 1'b0;
    checks++;
    if (act_fetch.size() != exp_fetch.size()) begin
      errors++; $display("FAIL %s fetch_count got=%0d exp=%0d", name, act_fetch.size(), exp_fetch.size());
    end
    for (int i = 0; i < act_fetch.size() && i < exp_fetch.size(); i++) begin
      checks++;
      if (act_fetch[i] != exp_fetch[i]) begin
        errors++; $display("FAIL %s fetch_addr[%0d] got=%0d exp=%0d", name, i, act_fetch[i], exp_fetch[i]);
      end
    end
    checks++;
    if (act_we.size() != exp_we.size()) begin
      errors++; $display("FAIL %s reg_we_count got=%0d exp=%0d", name, act_we.size(), exp_we.size());
    end
    for (int i = 0; i < act_we.size() && i < exp_we.size(); i++) begin
      checks++;
      if (act_we[i] != exp_we[i]) begin
        errors++; $display("FAIL %s reg_we_cycle[%0d] got=%0d exp=%0d", name, i, act_we[i], exp_we[i]);
      end
    end
    checks++;
    if (act_mem_s.size() != exp_mem_s.size()) begin
      errors++; $display("FAIL %s mem_en_cycles got=%0d exp=%0d", name, act_mem_s.size(), exp_mem_s.size());
    end
    for (int i = 0; i < act_mem_s.size() && i < exp_mem_s.size(); i++) begin
      checks++;
      if (act_mem_s[i] != exp_mem_s[i] || act_mem_rw[i] != exp_mem_rw[i]) begin
        errors++; $display("FAIL %s mem[%0d] got=s%0d/rw%0b exp=s%0d/rw%0b", name, i,
                           act_mem_s[i], act_mem_rw[i], exp_mem_s[i], exp_mem_rw[i]);
      end
    end
    checks++;
    if (first_halt != exp_halt_s) begin
      errors++; $display("FAIL %s halt_cycle got=%0d exp=%0d", name, first_halt, exp_halt_s);
    end
    checks++;
    if (Retired !== 16'(exp_ret) || Pc !== IADDR_W'(exp_pc) || Mem_err !== exp_err || Halted !== 1'b1) begin
      errors++; $display("FAIL %s final got=ret%0d/pc%0d/err%0b/halt%0b exp=ret%0d/pc%0d/err%0b/halt1",
                         name, Retired, Pc, Mem_err, Halted, exp_ret, exp_pc, exp_err);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    load_alu_program();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Enable_i, Mem_en, Mem_rw, Reg_we, Busy, Halted, Mem_err} !== 7'b0010000) begin
      errors++; $display("FAIL reset strobes got=%b exp=0010000", {Enable_i, Mem_en, Mem_rw, Reg_we, Busy, Halted, Mem_err});
    end
    checks++;
    if (Pc !== '0 || Address_in_i !== '0 || Instr_reg !== '0 || Retired !== '0) begin
      errors++; $display("FAIL reset regs got=pc%0d/addr%0d/ir%h/ret%0d exp=0", Pc, Address_in_i, Instr_reg, Retired);
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if ({Enable_i, Busy, Halted} !== 3'b000) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=000", i, {Enable_i, Busy, Halted});
      end
    end
  endtask

  task automatic test_alu_program();
    load_alu_program();
    run_program("alu16", 1'b0);
    checks++;
    if (first_halt != 64 || Retired !== 16'd16 || Pc !== 8'd16 || act_we.size() != 16) begin
      errors++; $display("FAIL alu16_spec got=halt%0d/ret%0d/pc%0d/we%0d exp=halt64/ret16/pc16/we16",
                         first_halt, Retired, Pc, act_we.size());
    end
  endtask

  task automatic test_mem_ops();
    load_alu_program();
    imem[2] = mk_instr(OP_STR); dly_tbl[2] = 3;
    imem[4] = mk_instr(OP_LDR); dly_tbl[4] = 3;
    run_program("mem_str_ldr", 1'b0);
  endtask

  task automatic test_timeout();
    load_alu_program();
    imem[1] = mk_instr(OP_LDR); dly_tbl[1] = 0;
    run_program("timeout", 1'b0);
    checks++;
    if (act_mem_s.size() != 15 || Mem_err !== 1'b1 || Retired !== 16'd1) begin
      errors++; $display("FAIL timeout_spec got=men%0d/err%0b/ret%0d exp=men15/err1/ret1", act_mem_s.size(), Mem_err, Retired);
    end
    imem[1] = mk_instr(OP_LDR); dly_tbl[1] = MEM_TIMEOUT;
    run_program("ready_at_limit", 1'b0);
  endtask

  task automatic test_cond_halt();
    load_alu_program();
    imem[5] = mk_instr(OP_LDR); cond_tbl[5] = 1'b0;
    imem[7] = mk_instr(OP_HALT);
    run_program("cond_halt", 1'b0);
    checks++;
    if (Pc !== 8'd7 || Retired !== 16'd7 || act_we.size() != 6 || act_mem_s.size() != 0) begin
      errors++; $display("FAIL cond_halt_spec got=pc%0d/ret%0d/we%0d/men%0d exp=pc7/ret7/we6/men0",
                         Pc, Retired, act_we.size(), act_mem_s.size());
    end
  endtask

  task automatic test_reset_mid_mem();
    load_alu_program();
    imem[0] = mk_instr(OP_LDR); dly_tbl[0] = 0;
    @(negedge Clk); Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (5) @(negedge Clk);
    checks++;
    if (Mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_mem precondition got=%0b exp=1", Mem_en);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Enable_i, Mem_en, Mem_rw, Reg_we, Busy, Halted, Mem_err} !== 7'b0010000) begin
      errors++; $display("FAIL rst_mem strobes got=%b exp=0010000", {Enable_i, Mem_en, Mem_rw, Reg_we, Busy, Halted, Mem_err});
    end
    checks++;
    if (Pc !== '0 || Address_in_i !== '0 || Instr_reg !== '0 || Retired !== '0) begin
      errors++; $display("FAIL rst_mem regs got=pc%0d/addr%0d/ir%h/ret%0d exp=0", Pc, Address_in_i, Instr_reg, Retired);
    end
    @(posedge Clk); @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if ({Reg_we, Mem_en, Busy} !== 3'b000) begin
        errors++; $display("FAIL rst_mem_after cyc=%0d got=%b exp=000", i, {Reg_we, Mem_en, Busy});
      end
    end
    imem[0] = mk_instr(OP_ALU); dly_tbl[0] = 1;
    run_program("rst_restart", 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 19);
        imem[i] = mk_instr(r < 9 ? OP_ALU : r < 14 ? OP_LDR : r < 19 ? OP_STR : OP_HALT);
        cond_tbl[i] = ($urandom_range(0, 4) != 0);
        dly_tbl[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MEM_TIMEOUT + 1);
      end
      run_program($sformatf("random%0d", n), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0;
    test_reset();
    test_alu_program();
    test_mem_ops();
    test_timeout();
    test_cond_halt();
    test_reset_mid_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_cpu_sequencer.md
MASTER_CPU_SEQUENCER -- requirements
Module: master_cpu_sequencer

Interface
REQ-001 SHALL have parameter IADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter PROG_LEN, default 16, number of instructions executed before automatic halt (1..2^IADDR_W).
REQ-003 SHALL have parameter OP_LDR, default 4'b1000, load opcode; OP_STR, default 4'b1001, store opcode; OP_HALT, default 4'b1111, halt opcode.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles waiting for Mem_ready.
REQ-005 SHALL have ports: Clk in 1 clock, rising edge; Reset in 1 asynchronous, active-high.
REQ-006 SHALL have ports: Start in 1, begin execution from address 0; Instr_in in 32, instruction RAM read data; Cond_pass in 1, ALU condition check result for the current instruction.
REQ-007 SHALL have ports: Mem_ready in 1, data RAM access complete; Enable_i out 1, instruction RAM enable; Address_in_i out IADDR_W, instruction address.
REQ-008 SHALL have ports: Instr_reg out 32, latched instruction; Mem_en out 1, data RAM enable; Mem_rw out 1 (1 read, 0 write); Reg_we out 1, register-bank writeback strobe.
REQ-009 SHALL have ports: Pc out IADDR_W; Busy out 1; Halted out 1; Mem_err out 1 sticky timeout error; Retired out 16, retired-instruction count.

Function
REQ-010 SHALL implement states IDLE, FETCH, LATCH, EXEC, MEM, WB, HALT, encoded in a single state register.
REQ-011 IDLE: Start=1 -> FETCH with Pc=0, Retired=0, Mem_err=0, Halted=0; otherwise stay.
REQ-012 FETCH: Enable_i=1, Address_in_i=Pc for exactly one cycle -> LATCH.
REQ-013 LATCH: Instr_reg <= Instr_in (one-cycle RAM read latency) -> EXEC.
REQ-014 EXEC (one cycle): Instr_reg[27:24]==OP_HALT -> HALT; Cond_pass=0 -> WB without side effects; opcode OP_LDR/OP_STR -> MEM; else -> WB.
REQ-015 MEM: Mem_en=1, Mem_rw=1 for OP_LDR, 0 for OP_STR; hold until Mem_ready=1, then -> WB; Mem_ready sampled in the same cycle Mem_en is high.
REQ-016 MEM timeout: after MEM_TIMEOUT cycles without Mem_ready, set Mem_err=1, drop Mem_en, -> HALT; Mem_ready arriving in the timeout cycle itself SHALL win (no error).
REQ-017 WB: Reg_we=1 for one cycle only if Cond_pass was 1 in EXEC and opcode != OP_STR; Retired increments by 1 (including condition-failed instructions); Pc increments.
REQ-018 WB: if incremented Pc == PROG_LEN -> HALT; else -> FETCH; Pc SHALL NOT wrap past PROG_LEN-1.
REQ-019 Retired SHALL saturate at 16'hFFFF.
REQ-020 HALT: Halted=1, all strobes 0; Start=1 -> restart exactly as from IDLE (REQ-011).
REQ-021 Start while in any state other than IDLE/HALT SHALL be ignored.
REQ-022 Busy=1 in FETCH, LATCH, EXEC, MEM, WB; 0 otherwise.
REQ-023 Enable_i, Mem_en, Reg_we SHALL be mutually exclusive in every cycle.
REQ-024 Every instruction not entering MEM SHALL take exactly 4 cycles FETCH->WB; memory instructions 4 + N cycles, N = cycles in MEM.

Reset
REQ-025 Reset=1 SHALL immediately force state IDLE, Pc=0, Instr_reg=0, Retired=0, Enable_i=0, Mem_en=0, Mem_rw=1, Reg_we=0, Busy=0, Halted=0, Mem_err=0, Address_in_i=0.
REQ-026 Reset asserted mid-MEM SHALL drop Mem_en the same instant with no Reg_we pulse afterwards.
REQ-027 After Reset deassertion, no activity until Start=1 sampled on a rising Clk edge.

Verification
REQ-028 Program of 16 ALU ops (opcode 0001, Cond_pass=1), Start pulse -> 16 Reg_we pulses spaced 4 cycles, Retired=16, Pc=16 clamp-halt, Halted=1 at cycle 65 after Start.
REQ-029 Instr at address 2 = OP_STR, Mem_ready after 3 cycles -> Mem_en high 3 cycles, Mem_rw=0, no Reg_we for that instruction; OP_LDR same delay -> Mem_rw=1, one Reg_we.
REQ-030 OP_LDR with Mem_ready held 0, MEM_TIMEOUT=15 -> Mem_en high 15 cycles, Mem_err=1, Halted=1, Retired unchanged.
REQ-031 Instruction at address 5 with Cond_pass=0 -> no Reg_we, no Mem_en, Retired still increments; OP_HALT at address 7 -> Halted=1, Pc=7, Retired=7.
REQ-032 Reset pulse during MEM of an OP_LDR -> all outputs at REQ-025 values within same cycle; Start afterwards re-executes from Pc=0.
REQ-033 Start pulses during Busy=1 -> ignored, Pc sequence unchanged; Start in HALT -> restart with Retired=0, Mem_err=0.
